sokoban_move_engine: RTL and testbench
======================================

# sokoban_move_engine

Computes the next Sokoban game state from the current state and a direction command, producing the before-move and after-move snapshots that the retract (undo) block stores and restores. Sits between the keypad/direction decoder and the retract block. It is the write side of the retract block's history interface: it drives `game_state_bm`, `game_state_mm`, `game_state_en` and `sel`. It scans the map sequentially to locate the player, evaluates the move, and commits with a one-cycle enable pulse.

## Interface
- `SEL_MOVE`, 2'd1: `sel` code driven with every committed move.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `move_req`  in  1  one-cycle move request; sampled only in IDLE.
- `move_dir`  in  2  00 up, 01 down, 10 left, 11 right; sampled with `move_req`.
- `game_state_cur`  in  134  current state: [133:128] 6-bit step count; [127:0] 64 cells × 2 bits, cell i = [2i+1:2i], i = row*8+col on an 8×8 grid. Cell codes: 00 floor, 01 wall, 10 box, 11 player.
- `goal_mask`  in  64  bit i set = cell i is a goal; static per level.
- `busy`  out  1  high from accept until commit/abort.
- `game_state_bm`  out  134  state latched at accept.
- `game_state_mm`  out  134  state after the move.
- `game_state_en`  out  1  one-cycle commit strobe to the retract block.
- `sel`  out  2  `SEL_MOVE` during `game_state_en`, else 2'd0.
- `move_blocked`  out  1  one-cycle pulse: move illegal, nothing committed.
- `no_player`  out  1  one-cycle pulse: no 11 cell found.
- `win`  out  1  level solved after the last commit.

## Operation
- States: IDLE, LOCATE, EVAL, COMMIT.
- IDLE: on `move_req`=1, latch `game_state_cur` into `game_state_bm`, latch `move_dir` and `goal_mask`, set scan index c=0, go to LOCATE, raise `busy`. `move_req` in any other state is ignored; no queuing.
- LOCATE: examine cell c of the latched state once per cycle. Code 11: record p=c and go to EVAL. Else if c=63: pulse `no_player`, go to IDLE. Else c=c+1.
- EVAL: compute target t and beyond b from p and direction. Up: −8. Down: +8. Left: −1 unless col=0. Right: +1 unless col=7. Row or column overflow means off-grid; there is no wrap between rows.
  - t off-grid or wall: blocked.
  - t floor: player moves, p←00, t←11.
  - t box: b off-grid, wall or box means blocked. Otherwise p←00, t←11, b←10.
  - Legal move: register the result in `game_state_mm` with step count +1 mod 64 (63→0), go to COMMIT.
  - Blocked: pulse `move_blocked`, leave `game_state_mm` unchanged, go to IDLE.
- COMMIT: assert `game_state_en`=1 and `sel`=`SEL_MOVE` for one cycle. Update `win` as: `goal_mask`≠0 and every goal cell in `game_state_mm` holds 10. Go to IDLE.
- `win` holds until the next commit or reset. Blocked moves do not change `win`.
- Goal occupancy is not encoded in the cell code. A player or floor on a goal remains legal.

## Timing
- Reset (synchronous, `rst`=1 at an edge): state IDLE; `busy`, `game_state_en`, `move_blocked`, `no_player`, `win` = 0; `sel`=0; `game_state_bm` and `game_state_mm` = 0. Reset in any state aborts the move with no strobe.
- Accept edge T0. Player at index p.
- Legal move:
  - `game_state_en` high during the cycle after edge T0+p+3.
  - `busy` high from T0+1 through T0+p+3, low after T0+p+4.
  - The next request is accepted at T0+p+4 at the earliest.
- Blocked: `move_blocked` high for the cycle after edge T0+p+2. `busy` falls at the same edge.
- No player: `no_player` high for the cycle after edge T0+64; `busy` falls there.
- `game_state_bm` and `game_state_mm` are stable from the strobe until the next accept.
- `game_state_cur` may change while busy without effect.

## Test plan
- Player at cell 9, cell 10 floor, count 5, dir right, req at T0:
  - `game_state_en` in the cycle after T0+12; `sel`=1.
  - `mm`: cell 9=00, cell 10=11, count 6.
  - `bm` equals the input state.
- Push: player cell 9, box cell 10, cell 11 floor, `goal_mask` bit 11 only, dir right: `mm` cells 9/10/11 = 00/11/10 and `win`=1 after the strobe.
- Blocked cases:
  - Player cell 8 (col 0), dir left.
  - Player 9, box 10, wall 11, dir right.
  - Player 9, box 10, box 11, dir right.
  - Required for each: `move_blocked` pulse, no `game_state_en`, `mm` unchanged.
- Count wrap: count 63, legal move gives count 0. All-floor map gives a `no_player` pulse in the cycle after T0+64, no strobe.
- Request while busy: second `move_req` at T0+3 is ignored and exactly one strobe occurs. `rst` at T0+5 leaves all outputs 0, state IDLE, no strobe.

Source files
------------

// File: rtl/sokoban_move_engine.sv
// Sokoban move engine: finds the player, applies one move, emits before/after snapshots.
// Latency: accept -> commit strobe at T0+p+4 (p = player cell); blocked at T0+p+3; no player at T0+65.
// Backpressure: none; requests arriving while busy are dropped, never queued.
module sokoban_move_engine (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         move_req_i,
  input  logic [1:0]   move_dir_i,
  input  logic [133:0] game_state_cur_i,
  input  logic [63:0]  goal_mask_i,
  output logic         busy_o,
  output logic [133:0] game_state_bm_o,
  output logic [133:0] game_state_mm_o,
  output logic         game_state_en_o,
  output logic [1:0]   sel_o,
  output logic         move_blocked_o,
  output logic         no_player_o,
  output logic         win_o
);

  localparam logic [1:0] SEL_MOVE = 2'd1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCATE = 2'd1;
  localparam logic [1:0] ST_EVAL   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  localparam logic [1:0] CELL_FLOOR  = 2'b00;
  localparam logic [1:0] CELL_BOX    = 2'b10;
  localparam logic [1:0] CELL_PLAYER = 2'b11;

  logic [1:0]   state_q, state_d;
  logic [5:0]   idx_q, idx_d;        // scan index; holds the player cell once found
  logic [1:0]   dir_q, dir_d;
  logic [63:0]  goal_q, goal_d;
  logic [133:0] bm_q, bm_d;
  logic [133:0] mm_q, mm_d;
  logic         busy_q, busy_d;
  logic         en_q, en_d;
  logic [1:0]   sel_q, sel_d;
  logic         blk_q, blk_d;
  logic         np_q, np_d;
  logic         win_q, win_d;

  logic [2:0]   row, col;
  logic         t_ok, b_ok;
  logic [5:0]   t_idx, b_idx;
  logic [1:0]   cur_cell, t_cell, b_cell;
  logic         legal;
  logic [133:0] moved;
  logic         win_calc;

  assign row = idx_q[5:3];
  assign col = idx_q[2:0];

  // Target and beyond cells for the latched direction; edge rows/cols never wrap.
  always_comb begin
    t_ok  = 1'b0;
    b_ok  = 1'b0;
    t_idx = idx_q;
    b_idx = idx_q;
    case (dir_q)
      2'b00: begin
        t_ok  = (row != 3'd0);
        b_ok  = (row >= 3'd2);
        t_idx = idx_q - 6'd8;
        b_idx = idx_q - 6'd16;
      end
      2'b01: begin
        t_ok  = (row != 3'd7);
        b_ok  = (row <= 3'd5);
        t_idx = idx_q + 6'd8;
        b_idx = idx_q + 6'd16;
      end
      2'b10: begin
        t_ok  = (col != 3'd0);
        b_ok  = (col >= 3'd2);
        t_idx = idx_q - 6'd1;
        b_idx = idx_q - 6'd2;
      end
      default: begin
        t_ok  = (col != 3'd7);
        b_ok  = (col <= 3'd5);
        t_idx = idx_q + 6'd1;
        b_idx = idx_q + 6'd2;
      end
    endcase
  end

  // Move legality and the resulting board, evaluated on the accept-time snapshot.
  always_comb begin
    cur_cell = bm_q[{idx_q, 1'b0} +: 2];
    t_cell   = bm_q[{t_idx, 1'b0} +: 2];
    b_cell   = bm_q[{b_idx, 1'b0} +: 2];
    legal    = t_ok && ((t_cell == CELL_FLOOR) ||
                        ((t_cell == CELL_BOX) && b_ok && (b_cell == CELL_FLOOR)));
    moved    = bm_q;
    if (t_cell == CELL_BOX) begin
      moved[{b_idx, 1'b0} +: 2] = CELL_BOX;
    end
    moved[{idx_q, 1'b0} +: 2] = CELL_FLOOR;
    moved[{t_idx, 1'b0} +: 2] = CELL_PLAYER;
    moved[133:128]            = bm_q[133:128] + 6'd1;
  end

  // Solved when there is at least one goal and every goal cell holds a box.
  always_comb begin
    win_calc = (goal_q != 64'd0);
    for (int i = 0; i < 64; i++) begin
      if (goal_q[i] && (mm_q[2*i +: 2] != CELL_BOX)) begin
        win_calc = 1'b0;
      end
    end
  end

  // Control FSM next-state and output pulses.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    goal_d  = goal_q;
    bm_d    = bm_q;
    mm_d    = mm_q;
    busy_d  = busy_q;
    en_d    = 1'b0;
    sel_d   = 2'd0;
    blk_d   = 1'b0;
    np_d    = 1'b0;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (move_req_i) begin
          bm_d    = game_state_cur_i;
          dir_d   = move_dir_i;
          goal_d  = goal_mask_i;
          idx_d   = 6'd0;
          busy_d  = 1'b1;
          state_d = ST_LOCATE;
        end
      end
      ST_LOCATE: begin
        if (cur_cell == CELL_PLAYER) begin
          state_d = ST_EVAL;
        end else if (idx_q == 6'd63) begin
          np_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      ST_EVAL: begin
        if (legal) begin
          mm_d    = moved;
          state_d = ST_COMMIT;
        end else begin
          blk_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        en_d    = 1'b1;
        sel_d   = SEL_MOVE;
        win_d   = win_calc;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any move in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 6'd0;
      dir_q   <= 2'd0;
      goal_q  <= 64'd0;
      bm_q    <= 134'd0;
      mm_q    <= 134'd0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= 2'd0;
      blk_q   <= 1'b0;
      np_q    <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      goal_q  <= goal_d;
      bm_q    <= bm_d;
      mm_q    <= mm_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      blk_q   <= blk_d;
      np_q    <= np_d;
      win_q   <= win_d;
    end
  end

  assign busy_o          = busy_q;
  assign game_state_bm_o = bm_q;
  assign game_state_mm_o = mm_q;
  assign game_state_en_o = en_q;
  assign sel_o           = sel_q;
  assign move_blocked_o  = blk_q;
  assign no_player_o     = np_q;
  assign win_o           = win_q;

endmodule

// File: tb/tb_sokoban_move_engine.sv
// Testbench for sokoban_move_engine: directed scenarios plus randomized boards
// checked against a grid-arithmetic reference model.
module tb_sokoban_move_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         move_req;
  logic [1:0]   move_dir;
  logic [133:0] cur;
  logic [63:0]  goal;
  logic         busy;
  logic [133:0] bm;
  logic [133:0] mm;
  logic         en;
  logic [1:0]   sel;
  logic         blocked;
  logic         no_player;
  logic         win;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state carried across moves
  logic [133:0] bm_exp  = '0;
  logic [133:0] mm_exp  = '0;
  logic         win_exp = 1'b0;

  always #5 clk = ~clk;

  sokoban_move_engine dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .move_req_i       (move_req),
    .move_dir_i       (move_dir),
    .game_state_cur_i (cur),
    .goal_mask_i      (goal),
    .busy_o           (busy),
    .game_state_bm_o  (bm),
    .game_state_mm_o  (mm),
    .game_state_en_o  (en),
    .sel_o            (sel),
    .move_blocked_o   (blocked),
    .no_player_o      (no_player),
    .win_o            (win)
  );

  task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: locate player, step on the 8x8 grid with row/col arithmetic.
  function automatic void ref_move(input logic [133:0] s, input logic [1:0] d,
                                   output int p, output bit legal, output logic [133:0] nxt);
    int r, c, dr, dc, tr, tc, br, bc, t, b;
    logic [1:0] tv, bv;
    p = -1;
    legal = 1'b0;
    nxt = s;
    for (int i = 0; i < 64; i++) if (p < 0 && s[2*i +: 2] == 2'b11) p = i;
    if (p < 0) return;
    r = p / 8; c = p % 8; dr = 0; dc = 0;
    case (d)
      2'd0: dr = -1;
      2'd1: dr = 1;
      2'd2: dc = -1;
      default: dc = 1;
    endcase
    tr = r + dr; tc = c + dc;
    if (tr < 0 || tr > 7 || tc < 0 || tc > 7) return;
    t = tr * 8 + tc;
    tv = s[2*t +: 2];
    if (tv == 2'b10) begin
      br = r + 2*dr; bc = c + 2*dc;
      if (br < 0 || br > 7 || bc < 0 || bc > 7) return;
      b = br * 8 + bc;
      bv = s[2*b +: 2];
      if (bv != 2'b00) return;
      nxt[2*b +: 2] = 2'b10;
    end else if (tv != 2'b00) begin
      return;
    end
    nxt[2*p +: 2] = 2'b00;
    nxt[2*t +: 2] = 2'b11;
    nxt[133:128] = s[133:128] + 6'd1;
    legal = 1'b1;
  endfunction

  function automatic logic win_of(input logic [133:0] s, input logic [63:0] g);
    if (g == 64'd0) return 1'b0;
    for (int i = 0; i < 64; i++) if (g[i] && s[2*i +: 2] != 2'b10) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [133:0] rand134();
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return w[133:0];
  endfunction

  // One request; samples every negedge k after accept edge T0 (k = cycles after T0).
  task automatic run_move(input string tag, input logic [133:0] s, input logic [63:0] g,
                          input logic [1:0] d, input int extra_k, input int rst_k);
    int p, en_k, en_cnt, blk_k, np_k, busy_cnt, sel_bad, exp_end;
    int exp_en_k, exp_blk_k, exp_np_k;
    bit legal;
    logic [1:0] sel_at_en;
    logic [133:0] nxt;
    ref_move(s, d, p, legal, nxt);
    en_k = -1; en_cnt = 0; blk_k = -1; np_k = -1; busy_cnt = 0; sel_bad = 0; sel_at_en = 2'd0;
    @(negedge clk);
    cur = s; goal = g; move_dir = d; move_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    move_req = 1'b0;
    cur = rand134();
    for (int k = 0; k <= 70; k++) begin
      if (en) begin
        en_cnt++;
        if (en_k < 0) begin en_k = k; sel_at_en = sel; end
      end else if (sel != 2'd0) begin
        sel_bad++;
      end
      if (blocked && blk_k < 0) blk_k = k;
      if (no_player && np_k < 0) np_k = k;
      busy_cnt += int'(busy);
      move_req = (k == extra_k);
      if (k == extra_k) move_dir = 2'($urandom_range(0, 3));
      rst = (k == rst_k);
      @(negedge clk);
    end
    move_req = 1'b0;
    rst = 1'b0;
    exp_en_k = -1; exp_blk_k = -1; exp_np_k = -1;
    if (rst_k >= 0) begin
      exp_end = rst_k + 1;
      bm_exp = '0; mm_exp = '0; win_exp = 1'b0;
    end else begin
      bm_exp = s;
      if (p < 0) begin
        exp_np_k = 64; exp_end = 64;
      end else if (legal) begin
        exp_en_k = p + 3; exp_end = p + 3;
        mm_exp = nxt;
        win_exp = win_of(nxt, g);
      end else begin
        exp_blk_k = p + 2; exp_end = p + 2;
      end
    end
    chk({tag, " en_cycle"}, 134'(en_k), 134'(exp_en_k));
    chk({tag, " en_count"}, 134'(en_cnt), 134'((exp_en_k >= 0) ? 1 : 0));
    chk({tag, " sel_at_en"}, 134'(sel_at_en), 134'((exp_en_k >= 0) ? 1 : 0));
    chk({tag, " sel_idle"}, 134'(sel_bad), 134'(0));
    chk({tag, " blocked_cycle"}, 134'(blk_k), 134'(exp_blk_k));
    chk({tag, " no_player_cycle"}, 134'(np_k), 134'(exp_np_k));
    chk({tag, " busy_cycles"}, 134'(busy_cnt), 134'(exp_end));
    chk({tag, " bm"}, bm, bm_exp);
    chk({tag, " mm"}, mm, mm_exp);
    chk({tag, " win"}, 134'(win), 134'(win_exp));
  endtask

  initial begin
    logic [133:0] s;
    logic [63:0] g;
    int pp, v;
    bit lg;
    logic [133:0] nx;

    rst = 1'b1; move_req = 1'b0; move_dir = 2'd0; cur = '0; goal = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 134'(busy), 134'(0));
    chk("reset en", 134'(en), 134'(0));
    chk("reset sel", 134'(sel), 134'(0));
    chk("reset blocked", 134'(blocked), 134'(0));
    chk("reset no_player", 134'(no_player), 134'(0));
    chk("reset win", 134'(win), 134'(0));
    chk("reset bm", bm, 134'd0);
    chk("reset mm", mm, 134'd0);

    // Simple step right
    s = '0; s[133:128] = 6'd5; s[2*9 +: 2] = 2'b11;
    run_move("step_right", s, 64'd0, 2'd3, -1, -1);

    // Push onto the only goal
    s = '0; s[2*9 +: 2] = 2'b11; s[2*10 +: 2] = 2'b10;
    g = 64'd0; g[11] = 1'b1;
    run_move("push_win", s, g, 2'd3, -1, -1);

    // Blocked cases (win from the push must persist)
    s = '0; s[2*8 +: 2] = 2'b11;
    run_move("blk_left_edge", s, 64'd0, 2'd2, -1, -1);
    s = '0; s[2*9 +: 2] = 2'b11; s[2*10 +: 2] = 2'b10; s[2*11 +: 2] = 2'b01;
    run_move("blk_box_wall", s, 64'd0, 2'd3, -1, -1);
    s = '0; s[2*9 +: 2] = 2'b11; s[2*10 +: 2] = 2'b10; s[2*11 +: 2] = 2'b10;
    run_move("blk_box_box", s, 64'd0, 2'd3, -1, -1);

    // Step counter wrap
    s = '0; s[133:128] = 6'd63; s[2*20 +: 2] = 2'b11;
    run_move("count_wrap", s, 64'd0, 2'd1, -1, -1);

    // No player on the board
    s = '0; s[133:128] = 6'd7;
    run_move("no_player", s, 64'd0, 2'd0, -1, -1);

    // Extra request while busy is dropped
    s = '0; s[2*9 +: 2] = 2'b11;
    run_move("req_busy", s, 64'd0, 2'd3, 2, -1);

    // Reset mid-scan aborts the move
    s = '0; s[2*30 +: 2] = 2'b11;
    run_move("rst_abort", s, 64'd0, 2'd0, -1, 4);

    // Randomized boards
    for (int n = 0; n < 40; n++) begin
      s = '0;
      s[133:128] = 6'($urandom_range(0, 63));
      for (int i = 0; i < 64; i++) begin
        v = $urandom_range(0, 9);
        s[2*i +: 2] = (v < 6) ? 2'b00 : ((v < 8) ? 2'b01 : 2'b10);
      end
      if ($urandom_range(0, 15) != 0) s[2*$urandom_range(0, 63) +: 2] = 2'b11;
      move_dir = 2'($urandom_range(0, 3));
      ref_move(s, move_dir, pp, lg, nx);
      case ($urandom_range(0, 2))
        0: g = 64'd0;
        1: g = {$urandom, $urandom};
        default: begin
          g = 64'd0;
          for (int i = 0; i < 64; i++) g[i] = (nx[2*i +: 2] == 2'b10);
        end
      endcase
      run_move($sformatf("rand%0d", n), s, g, move_dir, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
